// File: rtl/demux_sequencer_pkg.sv
// Shared types and constants for the demux sequencer: FSM state encoding,
// routing mode encodings and the number of destination channels.
package demux_sequencer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int NUM_CH = 4;

endpackage : demux_sequencer_pkg

// File: rtl/demux_sequencer_if.sv
// Bus bundle between the upstream producer, the sequencer and the demux
// datapath: the upstream valid/ready word plus the select, held word and
// per-channel valid/ready toward the four destinations.
interface demux_sequencer_if #(
    parameter int WIDTH = 8
);
    import demux_sequencer_pkg::*;

    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sel;
    logic [WIDTH-1:0]  out_data;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready;

    // Producer / destination side (drives words in, readies back)
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, sel, out_data, out_valid
    );

    // Sequencer side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, sel, out_data, out_valid
    );

endinterface : demux_sequencer_if

// File: rtl/demux_sequencer_wait_timer.sv
// Clearable saturating wait counter. Counts enabled cycles and raises a
// combinational terminal-count pulse on the TIMEOUT-th consecutive enabled
// cycle; the count restarts from zero after that pulse or on clear.
module demux_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;
    logic          w_tc;

    assign w_tc = i_en && (r_count == LAST);
    assign o_tc = w_tc;

    // Count consecutive enabled cycles; restart on clear or terminal count
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || w_tc) begin
            r_count <= '0;
        end else if (i_en && (r_count != LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : demux_wait_timer

// File: rtl/demux_sequencer.sv
// Demux sequencer: takes words from a valid/ready source, holds each one and
// drives the select plus one-hot valid toward four destinations. Routing is
// round-robin in bursts of BURST words or fixed to a chosen channel; a channel
// that stays not-ready for TIMEOUT cycles raises a timeout pulse (round-robin
// retries the word on the next channel, fixed mode keeps waiting).
module demux_sequencer
    import demux_sequencer_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_mode,
    input  logic [1:0]        i_fixed_ch,
    demux_sequencer_if.slave  bus,
    output logic              o_timeout_err
);
    localparam int BCW = $clog2(BURST) + 1;
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);

    state_t           r_state,  w_state_next;
    logic [1:0]       r_sel,    w_sel_next;
    logic [WIDTH-1:0] r_data,   w_data_next;
    logic             r_mode,   w_mode_next;
    logic [BCW-1:0]   r_burst_cnt, w_burst_cnt_next;
    logic             r_timeout_err, w_timeout_err_next;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_ready_sel;
    logic              w_deliver;
    logic              w_wait_en;
    logic              w_timeout;
    logic [NUM_CH-1:0] w_out_valid;

    // Only the selected channel's ready matters; the others are ignored
    assign w_ready_sel = bus.out_ready[r_sel];
    assign w_in_ready  = (r_state == ST_IDLE) && i_enable && !i_rst;
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_deliver   = (r_state == ST_DRIVE) && w_ready_sel;
    assign w_wait_en   = (r_state == ST_DRIVE) && !w_ready_sel;

    // Delivery clears the wait count; a ready arriving on the terminal
    // cycle disables counting, so delivery wins over timeout.
    demux_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_deliver),
        .i_en  (w_wait_en),
        .o_tc  (w_timeout)
    );

    // One-hot valid decoded from the registered select while a word is held
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_valid
            assign w_out_valid[gi] = (r_state == ST_DRIVE) && (r_sel == 2'(gi));
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.sel       = r_sel;
    assign bus.out_data  = r_data;
    assign bus.out_valid = w_out_valid;
    assign o_timeout_err = r_timeout_err;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= 2'd0;
            r_data        <= '0;
            r_mode        <= MODE_RR;
            r_burst_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_sel         <= w_sel_next;
            r_data        <= w_data_next;
            r_mode        <= w_mode_next;
            r_burst_cnt   <= w_burst_cnt_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    // Next-state: accept in IDLE, deliver or time out in DRIVE
    always_comb begin
        w_state_next       = r_state;
        w_sel_next         = r_sel;
        w_data_next        = r_data;
        w_mode_next        = r_mode;
        w_burst_cnt_next   = r_burst_cnt;
        w_timeout_err_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_data_next  = bus.in_data;
                    w_mode_next  = i_mode;
                    w_state_next = ST_DRIVE;
                    if (i_mode == MODE_FIXED) begin
                        w_sel_next       = i_fixed_ch;
                        w_burst_cnt_next = '0;
                    end
                end
            end
            ST_DRIVE: begin
                if (w_deliver) begin
                    w_state_next = ST_IDLE;
                    if (r_mode == MODE_RR) begin
                        if (r_burst_cnt == BURST_LAST) begin
                            w_burst_cnt_next = '0;
                            w_sel_next       = r_sel + 2'd1;
                        end else begin
                            w_burst_cnt_next = r_burst_cnt + 1'b1;
                        end
                    end
                end else if (w_timeout) begin
                    // Word stays held; round-robin retries it on the next channel
                    w_timeout_err_next = 1'b1;
                    if (r_mode == MODE_RR) begin
                        w_sel_next       = r_sel + 2'd1;
                        w_burst_cnt_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule : demux_sequencer

// File: tb/tb_demux_sequencer.sv
// Directed bench for demux_sequencer: reset mid-word, round-robin bursts,
// fixed channel, timeout retry, ready/timeout tie, fixed-mode repeated
// timeouts and enable deassertion during a held word.
module tb_demux_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       mode;
    logic [1:0] fixed_ch;
    logic       timeout_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    demux_sequencer_if #(.WIDTH(8)) bus ();

    demux_sequencer #(
        .WIDTH   (8),
        .BURST   (4),
        .TIMEOUT (15)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_mode        (mode),
        .i_fixed_ch    (fixed_ch),
        .bus           (bus),
        .o_timeout_err (timeout_err)
    );

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 4'b0000;
        enable        = 1'b1;
        mode          = 1'b0;
        fixed_ch      = 2'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; mode = 1'b0; fixed_ch = 2'd0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.in_ready, bus.out_valid, bus.sel, timeout_err} !== 8'h00)
                $display("FAIL reset_init cyc%0d: rdy/valid/sel/err=%b expected 00000000", c, {bus.in_ready, bus.out_valid, bus.sel, timeout_err});
            else pass_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.in_ready, bus.out_data} !== {1'b1, 8'h00})
            $display("FAIL reset_release: rdy=%b data=%h expected 1/00", bus.in_ready, bus.out_data);
        else pass_cnt++;
        // Put a word in flight, then reset in the middle of driving it
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total_cnt++;
        if ({bus.out_valid, bus.out_data} !== {4'b0001, 8'h77})
            $display("FAIL reset_pre_drive: valid=%b data=%h expected 0001/77", bus.out_valid, bus.out_data);
        else pass_cnt++;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.in_ready, bus.out_valid, bus.sel} !== 7'b0)
                $display("FAIL reset_mid_drive cyc%0d: rdy/valid/sel=%b expected 0000000", c, {bus.in_ready, bus.out_valid, bus.sel});
            else pass_cnt++;
        end
        rst = 1'b0;
        bus.out_ready = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== {1'b1, 4'b0000, 8'h00})
                $display("FAIL reset_word_lost cyc%0d: rdy=%b valid=%b data=%h expected 1/0000/00", c, bus.in_ready, bus.out_valid, bus.out_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_v;
        do_reset();
        bus.out_ready = 4'hF;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            exp_v = 4'b0001 << (i / 4);
            bus.in_valid = 1'b1; bus.in_data = 8'(i);
            @(negedge clk);
            bus.in_valid = 1'b0;
            total_cnt++;
            if ({bus.in_ready, bus.out_valid, bus.sel, bus.out_data} !== {1'b0, exp_v, 2'(i / 4), 8'(i)})
                $display("FAIL rr_drive word%0d: rdy=%b valid=%b sel=%0d data=%h expected 0/%b/%0d/%h", i, bus.in_ready, bus.out_valid, bus.sel, bus.out_data, exp_v, i / 4, i);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({bus.in_ready, bus.out_valid} !== {1'b1, 4'b0000})
                $display("FAIL rr_idle word%0d: rdy=%b valid=%b expected 1/0000", i, bus.in_ready, bus.out_valid);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.sel !== 2'd0)
            $display("FAIL rr_wrap: sel=%0d expected 0", bus.sel);
        else pass_cnt++;
    endtask

    task automatic test_fixed();
        do_reset();
        bus.out_ready = 4'hF; mode = 1'b1; fixed_ch = 2'd2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'h50 + 8'(i);
            @(negedge clk);
            bus.in_valid = 1'b0;
            total_cnt++;
            if ({bus.out_valid, bus.sel, bus.out_data} !== {4'b0100, 2'd2, 8'h50 + 8'(i)})
                $display("FAIL fixed_drive word%0d: valid=%b sel=%0d data=%h expected 0100/2/%h", i, bus.out_valid, bus.sel, bus.out_data, 8'h50 + 8'(i));
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({bus.in_ready, bus.out_valid, bus.sel} !== {1'b1, 4'b0000, 2'd2})
                $display("FAIL fixed_idle word%0d: rdy=%b valid=%b sel=%0d expected 1/0000/2", i, bus.in_ready, bus.out_valid, bus.sel);
            else pass_cnt++;
        end
        mode = 1'b0;
    endtask

    task automatic test_timeout_rr();
        do_reset();
        bus.out_ready = 4'b1110;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'hA5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            total_cnt++;
            if ({bus.out_valid, timeout_err} !== {4'b0001, 1'b0})
                $display("FAIL to_rr_wait cyc%0d: valid=%b err=%b expected 0001/0", c, bus.out_valid, timeout_err);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({timeout_err, bus.out_valid, bus.sel, bus.out_data} !== {1'b1, 4'b0010, 2'd1, 8'hA5})
            $display("FAIL to_rr_retry: err=%b valid=%b sel=%0d data=%h expected 1/0010/1/a5", timeout_err, bus.out_valid, bus.sel, bus.out_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({timeout_err, bus.out_valid, bus.in_ready, bus.sel} !== {1'b0, 4'b0000, 1'b1, 2'd1})
            $display("FAIL to_rr_delivered: err=%b valid=%b rdy=%b sel=%0d expected 0/0000/1/1", timeout_err, bus.out_valid, bus.in_ready, bus.sel);
        else pass_cnt++;
    endtask

    task automatic test_tie_and_fixed_timeout();
        logic exp_err;
        do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 15) bus.out_ready = 4'b0001;
            total_cnt++;
            if ({bus.out_valid, timeout_err} !== {4'b0001, 1'b0})
                $display("FAIL tie_wait cyc%0d: valid=%b err=%b expected 0001/0", c, bus.out_valid, timeout_err);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({timeout_err, bus.out_valid, bus.in_ready, bus.sel} !== {1'b0, 4'b0000, 1'b1, 2'd0})
            $display("FAIL tie_delivered: err=%b valid=%b rdy=%b sel=%0d expected 0/0000/1/0", timeout_err, bus.out_valid, bus.in_ready, bus.sel);
        else pass_cnt++;
        // Fixed mode: channel 3 never ready for 30 cycles -> two pulses
        bus.out_ready = 4'b0000; mode = 1'b1; fixed_ch = 2'd3;
        bus.in_valid = 1'b1; bus.in_data = 8'hC3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            if (c > 1) @(negedge clk);
            exp_err = (c == 16) || (c == 31);
            total_cnt++;
            if ({timeout_err, bus.out_valid, bus.sel, bus.out_data} !== {exp_err, 4'b1000, 2'd3, 8'hC3})
                $display("FAIL fixed_to cyc%0d: err=%b valid=%b sel=%0d data=%h expected %b/1000/3/c3", c, timeout_err, bus.out_valid, bus.sel, bus.out_data, exp_err);
            else pass_cnt++;
        end
        bus.out_ready = 4'b1000;
        @(negedge clk);
        total_cnt++;
        if ({bus.out_valid, bus.in_ready, timeout_err} !== {4'b0000, 1'b1, 1'b0})
            $display("FAIL fixed_to_release: valid=%b rdy=%b err=%b expected 0000/1/0", bus.out_valid, bus.in_ready, timeout_err);
        else pass_cnt++;
        mode = 1'b0;
    endtask

    task automatic test_enable();
        do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 8'h3C;
        @(negedge clk);
        bus.in_valid = 1'b0; enable = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== {1'b0, 4'b0001, 8'h3C})
                $display("FAIL en_hold cyc%0d: rdy=%b valid=%b data=%h expected 0/0001/3c", c, bus.in_ready, bus.out_valid, bus.out_data);
            else pass_cnt++;
            @(negedge clk);
        end
        bus.out_ready = 4'b0001; bus.in_valid = 1'b1; bus.in_data = 8'h99;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({bus.in_ready, bus.out_valid, bus.out_data} !== {1'b0, 4'b0000, 8'h3C})
                $display("FAIL en_idle cyc%0d: rdy=%b valid=%b data=%h expected 0/0000/3c", c, bus.in_ready, bus.out_valid, bus.out_data);
            else pass_cnt++;
        end
        enable = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL en_reenable: rdy=%b expected 1", bus.in_ready);
        else pass_cnt++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        total_cnt++;
        if ({bus.out_valid, bus.sel, bus.out_data} !== {4'b0001, 2'd0, 8'h99})
            $display("FAIL en_next_word: valid=%b sel=%0d data=%h expected 0001/0/99", bus.out_valid, bus.sel, bus.out_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({bus.out_valid, bus.in_ready} !== {4'b0000, 1'b1})
            $display("FAIL en_next_done: valid=%b rdy=%b expected 0000/1", bus.out_valid, bus.in_ready);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed();
        test_timeout_rr();
        test_tie_and_fixed_timeout();
        test_enable();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_demux_sequencer
